// File: rtl/ac_timer_run.sv
// Air-conditioner shutdown timer: loads a BCD hour count, runs it down as hh:mm:ss and requests power-off at zero.
// Optional last-minute blink on warn is enabled by defining AC_TIMER_WARN_EN.
module ac_timer_run #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_ones,
  input  logic       start,
  input  logic       cancel,
  output logic       off_req,
  output logic       expired,
  output logic       busy,
  output logic       load_err,
  output logic       warn,
  output logic       LED_RUN,
  output logic [7:0] HEX7,
  output logic [7:0] HEX6,
  output logic [7:0] HEX5,
  output logic [7:0] HEX4
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_EXPIRED} state_t;

  state_t          state, state_nx;
  logic [3:0]      hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
  logic [3:0]      hh_t_nx, hh_o_nx, mm_t_nx, mm_o_nx, ss_t_nx, ss_o_nx;
  logic [3:0]      d_hh_t, d_hh_o, d_mm_t, d_mm_o, d_ss_t, d_ss_o;
  logic [PW-1:0]   presc, presc_nx;
  logic            dp, dp_nx;
  logic            warn_r, warn_nx;
  logic            off_nx, lerr_nx;
  logic            tick, ld_ok, ld_zero, cnt_zero, d_zero;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hc0;
      4'd1:    seg7 = 8'hf9;
      4'd2:    seg7 = 8'ha4;
      4'd3:    seg7 = 8'hb0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hf8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hff;
    endcase
  endfunction

  assign ld_ok   = (hr_tens < 4'd2) || ((hr_tens == 4'd2) && (hr_ones <= 4'd4));
  assign ld_zero = (hr_tens == 4'd0) && (hr_ones == 4'd0);
  assign tick    = (state == S_RUN) && (presc == PRESC_LAST);
  assign cnt_zero = (hh_t == 4'd0) && (hh_o == 4'd0) && (mm_t == 4'd0) &&
                    (mm_o == 4'd0) && (ss_t == 4'd0) && (ss_o == 4'd0);

  // One-second BCD borrow chain; a zero count holds rather than wrapping.
  always_comb begin
    d_hh_t = hh_t;
    d_hh_o = hh_o;
    d_mm_t = mm_t;
    d_mm_o = mm_o;
    d_ss_t = ss_t;
    d_ss_o = ss_o;
    if (!cnt_zero) begin
      if (ss_o != 4'd0) begin
        d_ss_o = ss_o - 4'd1;
      end else if (ss_t != 4'd0) begin
        d_ss_t = ss_t - 4'd1;
        d_ss_o = 4'd9;
      end else begin
        d_ss_t = 4'd5;
        d_ss_o = 4'd9;
        if (mm_o != 4'd0) begin
          d_mm_o = mm_o - 4'd1;
        end else if (mm_t != 4'd0) begin
          d_mm_t = mm_t - 4'd1;
          d_mm_o = 4'd9;
        end else begin
          d_mm_t = 4'd5;
          d_mm_o = 4'd9;
          if (hh_o != 4'd0) begin
            d_hh_o = hh_o - 4'd1;
          end else begin
            d_hh_t = hh_t - 4'd1;
            d_hh_o = 4'd9;
          end
        end
      end
    end
  end

  assign d_zero = (d_hh_t == 4'd0) && (d_hh_o == 4'd0) && (d_mm_t == 4'd0) &&
                  (d_mm_o == 4'd0) && (d_ss_t == 4'd0) && (d_ss_o == 4'd0);

  always_comb begin
    state_nx = state;
    hh_t_nx  = hh_t;
    hh_o_nx  = hh_o;
    mm_t_nx  = mm_t;
    mm_o_nx  = mm_o;
    ss_t_nx  = ss_t;
    ss_o_nx  = ss_o;
    presc_nx = presc;
    dp_nx    = dp;
    off_nx   = 1'b0;
    lerr_nx  = 1'b0;
    warn_nx  = 1'b0;
    if (cancel) begin
      state_nx = S_IDLE;
      hh_t_nx  = 4'd0;
      hh_o_nx  = 4'd0;
      mm_t_nx  = 4'd0;
      mm_o_nx  = 4'd0;
      ss_t_nx  = 4'd0;
      ss_o_nx  = 4'd0;
      presc_nx = '0;
    end else if (state == S_RUN) begin
      if (tick) begin
        presc_nx = '0;
        dp_nx    = ~dp;
        hh_t_nx  = d_hh_t;
        hh_o_nx  = d_hh_o;
        mm_t_nx  = d_mm_t;
        mm_o_nx  = d_mm_o;
        ss_t_nx  = d_ss_t;
        ss_o_nx  = d_ss_o;
        if (d_zero) begin
          state_nx = S_EXPIRED;
          off_nx   = 1'b1;
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end else if (load) begin
      // A load in the same cycle as start takes precedence; start is dropped.
      if (!ld_ok) begin
        lerr_nx = 1'b1;
      end else begin
        state_nx = ld_zero ? S_IDLE : S_ARMED;
        hh_t_nx  = hr_tens;
        hh_o_nx  = hr_ones;
        mm_t_nx  = 4'd0;
        mm_o_nx  = 4'd0;
        ss_t_nx  = 4'd0;
        ss_o_nx  = 4'd0;
      end
    end else if (start && (state == S_ARMED)) begin
      state_nx = S_RUN;
      presc_nx = '0;
      dp_nx    = 1'b0;
    end
`ifdef AC_TIMER_WARN_EN
    if ((state_nx == S_RUN) && (hh_t_nx == 4'd0) && (hh_o_nx == 4'd0) &&
        (mm_t_nx == 4'd0) && (mm_o_nx == 4'd0))
      warn_nx = tick ? ~warn_r : warn_r;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh_t     <= 4'd0;
      hh_o     <= 4'd0;
      mm_t     <= 4'd0;
      mm_o     <= 4'd0;
      ss_t     <= 4'd0;
      ss_o     <= 4'd0;
      presc    <= '0;
      dp       <= 1'b0;
      warn_r   <= 1'b0;
      off_req  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      hh_t     <= hh_t_nx;
      hh_o     <= hh_o_nx;
      mm_t     <= mm_t_nx;
      mm_o     <= mm_o_nx;
      ss_t     <= ss_t_nx;
      ss_o     <= ss_o_nx;
      presc    <= presc_nx;
      dp       <= dp_nx;
      warn_r   <= warn_nx;
      off_req  <= off_nx;
      load_err <= lerr_nx;
    end
  end

  // Display stage: one cycle behind the count/state registers.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE)) begin
      HEX7 <= 8'hff;
      HEX6 <= 8'hff;
      HEX5 <= 8'hff;
      HEX4 <= 8'hff;
    end else begin
      HEX7 <= seg7(hh_t);
      HEX6 <= seg7(hh_o) & {((state == S_RUN) ? dp : 1'b1), 7'h7f};
      HEX5 <= seg7(mm_t);
      HEX4 <= seg7(mm_o);
    end
  end

  assign warn    = warn_r;
  assign expired = (state == S_EXPIRED);
  assign busy    = (state == S_ARMED) || (state == S_RUN);
  assign LED_RUN = (state == S_RUN);

endmodule

// File: tb/tb_ac_timer_run.sv
// Directed bench for ac_timer_run with TICK_DIV=4; expected values are hand-computed.
module tb_ac_timer_run;

  logic       clk = 1'b0;
  logic       rst, load, start, cancel;
  logic [3:0] hr_tens, hr_ones;
  logic       off_req, expired, busy, load_err, warn, LED_RUN;
  logic [7:0] HEX7, HEX6, HEX5, HEX4;

  int vectors = 0;
  int miscompares = 0;

  ac_timer_run #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .hr_tens(hr_tens), .hr_ones(hr_ones),
    .start(start), .cancel(cancel), .off_req(off_req), .expired(expired),
    .busy(busy), .load_err(load_err), .warn(warn), .LED_RUN(LED_RUN),
    .HEX7(HEX7), .HEX6(HEX6), .HEX5(HEX5), .HEX4(HEX4)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; hr_tens = t; hr_ones = o;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_hex(input string tag, input logic [7:0] h7, input logic [7:0] h6,
                           input logic [7:0] h5, input logic [7:0] h4);
    check_val({tag, "_hex7"}, HEX7, h7);
    check_val({tag, "_hex6"}, HEX6, h6);
    check_val({tag, "_hex5"}, HEX5, h5);
    check_val({tag, "_hex4"}, HEX4, h4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first_k, warn_hi, busy_hi;
    rst = 1'b1; load = 1'b0; start = 1'b0; cancel = 1'b0;
    hr_tens = 4'd0; hr_ones = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_hex("reset", 8'hff, 8'hff, 8'hff, 8'hff);
    check_val("reset_busy", busy, 0);
    check_val("reset_off_req", off_req, 0);
    check_val("reset_expired", expired, 0);
    check_val("reset_load_err", load_err, 0);
    check_val("reset_led_run", LED_RUN, 0);
    check_val("reset_warn", warn, 0);

    // Invalid loads, then a valid 24 h load.
    do_load(4'd2, 4'd5);
    check_val("ld25_err", load_err, 1);
    check_val("ld25_busy", busy, 0);
    @(negedge clk);
    check_val("ld25_err_pulse", load_err, 0);
    do_load(4'd3, 4'd0);
    check_val("ld30_err", load_err, 1);
    do_load(4'd2, 4'd4);
    check_val("ld24_busy", busy, 1);
    check_val("ld24_err", load_err, 0);
    @(negedge clk);
    check_hex("ld24", 8'ha4, 8'h99, 8'hc0, 8'hc0);

    // load and start together: load wins, stays ARMED.
    load = 1'b1; start = 1'b1; hr_tens = 4'd0; hr_ones = 4'd1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check_val("ldstart_led_run", LED_RUN, 0);
    check_val("ldstart_busy", busy, 1);
    @(negedge clk);
    check_hex("ld01", 8'hc0, 8'hf9, 8'hc0, 8'hc0);

    // Run 01:00:00 to expiry; k counts negedges after start was sampled.
    do_start();
    check_val("run_led_run", LED_RUN, 1);
    @(negedge clk);
    check_hex("run_k1", 8'hc0, 8'h79, 8'hc0, 8'hc0);
    repeat (4) @(negedge clk);
    check_hex("run_1tick", 8'hc0, 8'hc0, 8'h92, 8'h90);
    pulses = 0; first_k = -1; warn_hi = 0;
    for (int k = 6; k <= 14410; k++) begin
      @(negedge clk);
      if (off_req) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (warn) warn_hi++;
`ifdef AC_TIMER_WARN_EN
      if (k == 4 * 3540) check_val("warn_pre", warn, 0);
      if (k == 4 * 3541) check_val("warn_first", warn, 1);
      if (k == 4 * 3542) check_val("warn_toggle", warn, 0);
      if (k == 4 * 3543) check_val("warn_toggle2", warn, 1);
`endif
    end
    check_val("off_req_pulses", pulses, 1);
    check_val("off_req_cycle", first_k, 14400);
`ifdef AC_TIMER_WARN_EN
    check_val("warn_cycles", warn_hi, 30 * 4);
`else
    check_val("warn_cycles", warn_hi, 0);
`endif
    check_val("exp_expired", expired, 1);
    check_val("exp_busy", busy, 0);
    check_val("exp_led_run", LED_RUN, 0);
    check_val("exp_warn", warn, 0);
    check_hex("exp", 8'hc0, 8'hc0, 8'hc0, 8'hc0);

    // Reload from EXPIRED, run, then cancel with a simultaneous start.
    do_load(4'd0, 4'd1);
    check_val("reld_expired", expired, 0);
    check_val("reld_busy", busy, 1);
    do_start();
    repeat (6) @(negedge clk);
    do_load(4'd2, 4'd5);
    check_val("run_ld_err", load_err, 0);
    check_val("run_ld_led_run", LED_RUN, 1);
    cancel = 1'b1; start = 1'b1;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check_val("cancel_busy", busy, 0);
    check_val("cancel_led_run", LED_RUN, 0);
    check_val("cancel_expired", expired, 0);
    @(negedge clk);
    check_hex("cancel", 8'hff, 8'hff, 8'hff, 8'hff);
    pulses = 0; busy_hi = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (off_req) pulses++;
      if (busy) busy_hi++;
    end
    check_val("cancel_no_off_req", pulses, 0);
    check_val("cancel_stays_idle", busy_hi, 0);

    // Valid 00 load returns to IDLE.
    do_load(4'd1, 4'd2);
    check_val("ld12_busy", busy, 1);
    @(negedge clk);
    check_val("ld12_hex7", HEX7, 8'hf9);
    check_val("ld12_hex6", HEX6, 8'ha4);
    do_load(4'd0, 4'd0);
    check_val("ld00_busy", busy, 0);
    check_val("ld00_err", load_err, 0);
    @(negedge clk);
    check_val("ld00_hex7", HEX7, 8'hff);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
